// File: rtl/cond_accum_bank_if.sv
// Bundle of the operand, control and dump-stream signals of cond_accum_bank.
// The master side drives requests; the slave side (the bank) answers them.
interface cond_accum_bank_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  localparam int CB = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  // Operand handshake: a beat transfers on a clock edge where in_valid && in_ready.
  logic                in_valid;
  logic                in_ready;
  logic [CB-1:0]       in_chan;
  logic                in_cond;
  logic [WIDTH-1:0]    in_val_true;
  logic [WIDTH-1:0]    in_val_false;
  logic                clear;
  logic                dump_start;
  logic                dump_busy;
  logic                out_valid;
  logic [CB-1:0]       out_chan;
  logic [WIDTH-1:0]    out_value;
  logic                out_ovf;
  logic [CHANNELS-1:0] ovf_flags;
  logic                dbg_state;

  modport master (
    output in_valid, in_chan, in_cond, in_val_true, in_val_false, clear, dump_start,
    input  in_ready, dump_busy, out_valid, out_chan, out_value, out_ovf, ovf_flags, dbg_state
  );

  modport slave (
    input  in_valid, in_chan, in_cond, in_val_true, in_val_false, clear, dump_start,
    output in_ready, dump_busy, out_valid, out_chan, out_value, out_ovf, ovf_flags, dbg_state
  );
endinterface

// File: rtl/cond_accum_bank.sv
// Bank of CHANNELS conditional accumulators with sticky overflow flags,
// synchronous clear and a sequential dump engine that streams every channel.
module cond_accum_bank #(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 4,
  parameter int SATURATE   = 0,
  parameter int DUMP_CLEAR = 0
) (
  input  logic               clock,
  input  logic               reset,
  cond_accum_bank_if.slave   bus
);
  localparam int CB = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CB-1:0] LAST_IDX = CB'(CHANNELS - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_DUMP = 1'b1
  } state_t;

  state_t              r_state;
  logic [CB-1:0]       r_idx;
  logic [WIDTH-1:0]    r_acc [CHANNELS];
  logic [CHANNELS-1:0] r_ovf;
  logic                r_out_valid;
  logic [CB-1:0]       r_out_chan;
  logic [WIDTH-1:0]    r_out_value;
  logic                r_out_ovf;

  logic                w_chan_ok;
  logic [CB-1:0]       w_rd_chan;
  logic                w_accept;
  logic [WIDTH-1:0]    w_op;
  logic [WIDTH:0]      w_sum;
  logic                w_carry;
  logic [WIDTH-1:0]    w_new;

  // Out-of-range channels read channel 0 but are never written back.
  always_comb begin
    w_chan_ok = ({1'b0, bus.in_chan} < CHANNELS[CB:0]);
    w_rd_chan = w_chan_ok ? bus.in_chan : '0;
    w_accept  = bus.in_valid && (r_state == S_IDLE) && w_chan_ok;
    w_op      = bus.in_cond ? bus.in_val_true : bus.in_val_false;
    w_sum     = {1'b0, r_acc[w_rd_chan]} + {1'b0, w_op};
    w_carry   = w_sum[WIDTH];
    w_new     = w_sum[WIDTH-1:0];
    if (w_carry && (SATURATE != 0)) begin
      w_new = '1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_ovf       <= '0;
      r_out_valid <= 1'b0;
      r_out_chan  <= '0;
      r_out_value <= '0;
      r_out_ovf   <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        r_acc[i] <= '0;
      end
    end else if (bus.clear) begin
      // Clear outranks accumulation and dump_start, and aborts a running dump.
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_ovf       <= '0;
      r_out_valid <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        r_acc[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          r_out_valid <= 1'b0;
          if (w_accept) begin
            r_acc[w_rd_chan] <= w_new;
            if (w_carry) begin
              r_ovf[w_rd_chan] <= 1'b1;
            end
          end
          if (bus.dump_start) begin
            r_state <= S_DUMP;
            r_idx   <= '0;
          end
        end
        S_DUMP: begin
          r_out_valid <= 1'b1;
          r_out_chan  <= r_idx;
          r_out_value <= r_acc[r_idx];
          r_out_ovf   <= r_ovf[r_idx];
          if (DUMP_CLEAR != 0) begin
            r_acc[r_idx] <= '0;
            r_ovf[r_idx] <= 1'b0;
          end
          if (r_idx == LAST_IDX) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + CB'(1);
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.dump_busy = (r_state == S_DUMP);
  assign bus.out_valid = r_out_valid;
  assign bus.out_chan  = r_out_chan;
  assign bus.out_value = r_out_value;
  assign bus.out_ovf   = r_out_ovf;
  assign bus.ovf_flags = r_ovf;
  assign bus.dbg_state = r_state;
endmodule

// File: doc/cond_accum_bank.md
Name: cond_accum_bank

Overview:
- Parametrised successor to the single-register tick/tock accumulator submodule.
- Holds CHANNELS independent WIDTH-bit accumulators.
- Each accepted input adds one of two operands to the addressed channel; a condition bit picks the operand, which is the if/else dispatch the parent module used to do.
- Adds wrap/saturate overflow handling, sticky overflow flags, a synchronous clear, and a sequential dump engine that streams every channel out. Sits beneath control blocks that previously instantiated one accumulator per counter.

Parameters:
- WIDTH, 8, accumulator and operand width in bits.
- CHANNELS, 4, number of accumulators (>=2). CB = clog2(CHANNELS).
- SATURATE, 0, 0 = wrap modulo 2^WIDTH; 1 = clamp at 2^WIDTH-1.
- DUMP_CLEAR, 0, 1 = each channel and its flag are zeroed in the cycle it is dumped.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand request.
- in_ready  output  1  = !dump_busy; input accepted when in_valid && in_ready.
- in_chan  input  CB  target channel; values >= CHANNELS are dropped, nothing updated.
- in_cond  input  1  1 selects in_val_true, 0 selects in_val_false.
- in_val_true  input  WIDTH  operand when in_cond=1.
- in_val_false  input  WIDTH  operand when in_cond=0.
- clear  input  1  synchronous clear of all accumulators and flags.
- dump_start  input  1  begin dump; honoured only in IDLE.
- dump_busy  output  1  high while the FSM is in DUMP.
- out_valid  output  1  dump beat valid, registered.
- out_chan  output  CB  channel of the current beat.
- out_value  output  WIDTH  accumulator value of the current beat.
- out_ovf  output  1  overflow flag of the current beat.
- ovf_flags  output  CHANNELS  live sticky overflow flags, bit i = channel i.

Behaviour:
- Reset (async assert, sync release): every acc = 0, ovf_flags = 0, FSM = IDLE, idx = 0, out_valid = 0, out_chan = 0, out_value = 0, out_ovf = 0. Reset mid-dump aborts the dump immediately.
- Accumulate: on an accepted beat, op = in_cond ? in_val_true : in_val_false, and sum = acc[in_chan] + op is computed WIDTH+1 bits wide. acc updates at that clock edge (latency 1). Carry set means:
  - wrap mode: acc = sum[WIDTH-1:0] and the flag is set;
  - saturate mode: acc = all-ones and the flag is set.
  Flags are sticky until clear, reset, or a DUMP_CLEAR dump.
- FSM states: IDLE, DUMP.
  - IDLE -> DUMP when dump_start && !clear; idx <= 0.
  - Each edge in DUMP registers out_valid=1, out_chan=idx, out_value=acc[idx] and out_ovf=flag[idx], then idx++. After idx == CHANNELS-1 the FSM returns to IDLE.
  - Each edge in IDLE registers out_valid=0.
- Dump timing: dump_start sampled at edge E0. dump_busy is high for the CHANNELS cycles after E0. out_valid is high for the CHANNELS cycles after E0+1, on channels 0..CHANNELS-1 in order; there is no backpressure.
- An input accepted at E0 (same cycle as dump_start) is included in the dump. in_ready is low throughout DUMP, so no accumulation occurs during a dump.
- DUMP_CLEAR=1: the channel read at a DUMP edge is zeroed and its flag cleared at that same edge.
- clear has priority over everything.
  - All acc and flags go to 0 at the edge.
  - A dump in progress is aborted: FSM = IDLE, out_valid = 0 at that edge.
  - A simultaneous accepted input or dump_start is discarded.
- dump_start during DUMP is ignored. Simultaneous dump_start and clear: clear wins, no dump.

Test Plan:
- Reset, W=8, C=4: assert reset mid-idle -> all out_* = 0, ovf_flags = 4'b0000, in_ready = 1; then dump -> four beats, chan 0..3, value 0.
- Conditional dispatch, chan 2, true=72, false=36: cond=1 three beats, then cond=0 one beat -> dump beat 2 shows 252, ovf 0; other channels 0.
- Wrap, SATURATE=0: chan 2 = 252, add 36 -> acc 32, ovf_flags = 4'b0100 persists until clear. Saturate, SATURATE=1: same stimulus -> acc 255, flag set, further adds keep 255.
- Dump with input on the same edge as dump_start (chan 1 +5): beat 1 shows 5. in_valid held during the dump -> in_ready = 0 for 4 cycles, acc unchanged. DUMP_CLEAR=1: second dump reads all zero, flags = 0.
- Clear on the 2nd dump cycle (with in_valid high to chan 0, +9): out_valid drops the next cycle, FSM IDLE, all acc 0, the chan 0 add is lost.
- Async reset asserted between edges during DUMP: outputs go to 0 without a clock edge. After release, dump_start restarts cleanly at channel 0.
